// File: rtl/morse_keyer.sv
// Morse keyer: turns a 24-bit element word (12 two-bit elements, MSB pair first)
// into a timed on/off key signal, with a valid/ready handshake for back-to-back words.
module morse_keyer #(
  parameter int unsigned UNIT_CYCLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] x,
  input  logic        x_valid,
  output logic        ready,
  output logic        key,
  output logic        busy,
  output logic        done
);

  localparam int unsigned WORD_W = 24;

  localparam logic [1:0] EL_TERM = 2'b00;
  localparam logic [1:0] EL_DOT  = 2'b01;
  localparam logic [1:0] EL_WS   = 2'b10;
  localparam logic [1:0] EL_DASH = 2'b11;

  // Down-counter reload values: a phase of N units lasts N*UNIT_CYCLES cycles.
  localparam logic [CNT_W-1:0] LEN_1U = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LEN_3U = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LEN_7U = CNT_W'(7 * UNIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   sr_q, sr_d;
  logic [WORD_W-1:0]   sr_shift;
  logic [1:0]          next_el;
  logic                cnt_zero;
  logic                key_q, key_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  // Zeros shift in, so an exhausted word naturally reads as a terminator.
  assign sr_shift = sr_q << 2;
  assign next_el  = sr_shift[WORD_W-1 -: 2];
  assign cnt_zero = (cnt_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      key_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      key_q   <= key_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, counter and shift-register logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    case (state_q)
      IDLE: begin
        if (x_valid) begin
          // A leading terminator discards the whole word.
          sr_d = (x[WORD_W-1 -: 2] == EL_TERM) ? '0 : x;
          case (x[WORD_W-1 -: 2])
            EL_DOT:  begin state_d = MARK; cnt_d = LEN_1U; end
            EL_DASH: begin state_d = MARK; cnt_d = LEN_3U; end
            EL_WS:   begin state_d = GAP;  cnt_d = LEN_7U; end
            default: begin state_d = GAP;  cnt_d = LEN_3U; end
          endcase
        end
      end
      MARK: begin
        if (cnt_zero) begin
          state_d = GAP;
          cnt_d   = (next_el == EL_TERM) ? LEN_3U : LEN_1U;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_zero) begin
          sr_d = sr_shift;
          case (next_el)
            EL_DOT:  begin state_d = MARK; cnt_d = LEN_1U; end
            EL_DASH: begin state_d = MARK; cnt_d = LEN_3U; end
            EL_WS:   begin state_d = GAP;  cnt_d = LEN_7U; end
            default: begin state_d = IDLE; cnt_d = '0;     end
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode, registered alongside the state
  always_comb begin
    key_d   = 1'b0;
    done_d  = 1'b0;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    key_d   = (state_d == MARK);
    done_d  = (state_q == GAP) && (state_d == IDLE);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  assign key   = key_q;
  assign done  = done_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule

// File: doc/morse_keyer.md
Name: morse_keyer

Overview:
- Downstream stage of the Morse coder `cd`. Accepts one 24-bit code word and turns it into a timed on/off key signal, `key`, following standard Morse unit timing.
- Code word format: 12 two-bit elements, MSB-pair first, `x[23:22]` first.
- Element codes: 2'b01 = dot, 2'b11 = dash, 2'b10 = word space, 2'b00 = terminator (this element and all later ones are ignored).
- Provides a valid/ready handshake so an upstream sequencer can stream characters back-to-back.

Parameters:
- UNIT_CYCLES, 4: clock cycles per Morse time unit; must be ≥ 1.
- CNT_W, 16: width of the unit-cycle/duration counter; must hold 7*UNIT_CYCLES.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- x  input  24  code word from `cd`.
- x_valid  input  1  `x` is valid this cycle.
- ready  output  1  keyer idle; a word is accepted on a rising edge where `ready && x_valid`.
- key  output  1  Morse key output (1 = tone on); registered.
- busy  output  1  a word is being keyed; equals `~ready`.
- done  output  1  one-cycle pulse when the last gap of a word completes.

Behaviour:
- Reset (`rst_n == 0` at a rising edge):
  - state = IDLE; key = 0, done = 0, ready = 1, busy = 0.
  - Shift register and counter cleared.
  - Reset mid-word aborts immediately: key = 0 on the following cycle, no done pulse.
- FSM states: IDLE, MARK, GAP.
- IDLE:
  - ready = 1. On accept, latch `x` into a 24-bit shift register and decode the first element on the same edge.
  - dot → MARK for 1 unit, key = 1 from that edge.
  - dash → MARK for 3 units, key = 1 from that edge.
  - word space → GAP for 7 units, key = 0.
  - terminator (including an all-zero word) → GAP for 3 units, key = 0.
- MARK:
  - key = 1 for exactly N*UNIT_CYCLES cycles, then GAP with key = 0.
  - Gap length is 1 unit if the next element is dot, dash or word space; 3 units if the next element is a terminator or no elements remain.
- GAP:
  - key = 0 for the programmed length. At expiry, shift the register left by 2 and decode the next element.
  - dot/dash → MARK. Word space → GAP for 7 units; the preceding 1-unit gap is not merged.
  - terminator or end of word → IDLE with a done pulse.
- Final-gap exit:
  - done = 1 and ready = 1 for the cycle after the final gap's last cycle.
  - A new word may be accepted on that same edge (`ready && x_valid`): zero idle cycles between words.
- Duration counting: the down-counter loads N*UNIT_CYCLES−1 and the phase ends at count 0. Durations are exact; no off-by-one.
- `x_valid` while busy is ignored; `x` is sampled only at accept.
- At most 12 elements per word; after the 12th element the end-of-word 3-unit gap applies.
- Longest word (12 dashes): 12*3 + 11*1 + 3 = 50 units.

Test Plan (UNIT_CYCLES = 2):
- 'E', `x` = 24'h400000 accepted at edge 0 → key = 1 for 2 cycles, key = 0 for 6 cycles; done pulses in cycle 8; ready = 1 in cycle 8.
- 'A', `x` = 24'h700000 → key pattern 1×2, 0×2, 1×6, 0×6; done after 16 cycles.
- Word space `x` = 24'h800000 → key = 0 for 14 cycles, then done. All-zero word → key = 0 for 6 cycles, then done.
- Twelve dots, `x` = 24'h555555 → 12 high pulses of 2 cycles each, separated by 2-cycle gaps, final gap 6 cycles; total 52 cycles to done.
- Back-to-back: `x_valid` held high with 'E' then 'T' (24'hC00000) → 'T' accepted in the done cycle; key rises immediately; key = 1 for 6 cycles. `x_valid` pulses while busy have no effect.
- Reset: `rst_n` = 0 for 1 cycle during a dash (cycle 3) → next cycle key = 0, ready = 1, busy = 0, no done pulse. A following 'E' is keyed normally.
